// File: rtl/compare_loader.sv
// Serial-to-parallel loader for the compare counter: synchronizes a 3-wire serial link, validates
// each frame length, and applies the committed word to compare atomically, optionally on a match.
module compare_loader #(
    parameter int unsigned      WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_clk,
    input  logic             ser_data,
    input  logic             ser_latch,
    input  logic             update_mode,
    input  logic             compare_match,
    output logic [WIDTH-1:0] compare,
    output logic             pending,
    output logic             load_done,
    output logic             frame_err
);

    // Bit counter must hold WIDTH+1, the saturating overrun marker.
    localparam int unsigned     CntW    = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOvr  = CntW'(WIDTH + 1);

    logic [2:0]       sclk_q;
    logic [2:0]       slat_q;
    logic [1:0]       sdat_q;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic             pending_q, pending_d;
    logic             load_done_q;
    logic             frame_err_q;

    logic             sclk_rise;
    logic             latch_lvl;
    logic             latch_rise;
    logic             bit_in;
    logic             shift_en;
    logic             commit_ok;
    logic             commit_bad;
    logic             apply;

    // Data takes the same two-flop path as the strobes so it lines up with the detected edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            slat_q <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], ser_clk};
            slat_q <= {slat_q[1:0], ser_latch};
            sdat_q <= {sdat_q[0], ser_data};
        end
    end

    always_comb begin
        sclk_rise  = sclk_q[1] & ~sclk_q[2];
        latch_lvl  = slat_q[1];
        latch_rise = slat_q[1] & ~slat_q[2];
        bit_in     = sdat_q[1];
        shift_en   = sclk_rise & ~latch_lvl;
        commit_ok  = latch_rise & (bit_cnt_q == CntFull);
        commit_bad = latch_rise & (bit_cnt_q != CntFull);
        apply      = pending_q & (~update_mode | compare_match);
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (latch_rise) begin
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shift_d = {shift_q[WIDTH-2:0], bit_in};
            if (bit_cnt_q != CntOvr) begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end
    end

    // Apply reads the old shadow while a same-cycle commit writes the new one; commit keeps
    // pending set so the new value is not lost.
    always_comb begin
        shadow_d  = commit_ok ? shift_q : shadow_q;
        compare_d = apply ? shadow_q : compare_q;
        pending_d = commit_ok | (pending_q & ~apply);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            shadow_q    <= '0;
            compare_q   <= RESET_VALUE;
            pending_q   <= 1'b0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            shadow_q    <= shadow_d;
            compare_q   <= compare_d;
            pending_q   <= pending_d;
            load_done_q <= apply;
            frame_err_q <= commit_bad;
        end
    end

    assign compare   = compare_q;
    assign pending   = pending_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_compare_loader.sv
// Directed bench for compare_loader: serial frames driven at pin level, loads checked through a
// scoreboard of expected compare values plus direct latency and corner-case assertions.
module tb_compare_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_latch = 1'b0;
    logic        update_mode = 1'b0;
    logic        compare_match = 1'b0;
    logic [19:0] compare;
    logic        pending;
    logic        load_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ld_cnt = 0;
    int fe0;
    int ld0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    compare_loader #(
        .WIDTH       (20),
        .RESET_VALUE (20'h00000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ser_clk       (ser_clk),
        .ser_data      (ser_data),
        .ser_latch     (ser_latch),
        .update_mode   (update_mode),
        .compare_match (compare_match),
        .compare       (compare),
        .pending       (pending),
        .load_done     (load_done),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done) begin
            obs_q.push_back(compare);
            ld_cnt <= ld_cnt + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser_data = v[i];
            cyc(2);
            ser_clk = 1'b1;
            cyc(4);
            ser_clk = 1'b0;
            cyc(4);
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n);
        send_bits(v, n);
        ser_latch = 1'b1;
        cyc(5);
        ser_latch = 1'b0;
        cyc(4);
    endtask

    task automatic sb_drain(input string tag);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 50) begin
            cyc(1);
            n++;
        end
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("rst_compare", compare, 20'h00000);
        check("rst_pending", pending, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);

        // Valid frame, immediate mode, with exact latency
        send_bits(32'hABCDE, 20);
        exp_q.push_back(20'hABCDE);
        ser_latch = 1'b1;
        cyc(3);
        check("t1_pending_up", pending, 1'b1);
        check("t1_compare_old", compare, 20'h00000);
        cyc(1);
        check("t1_compare_new", compare, 20'hABCDE);
        check("t1_load_done", load_done, 1'b1);
        check("t1_pending_clr", pending, 1'b0);
        cyc(1);
        check("t1_load_done_end", load_done, 1'b0);
        cyc(3);
        ser_latch = 1'b0;
        cyc(3);
        check("t1_no_frame_err", fe_cnt, 0);
        sb_drain("t1_sb");

        // Short frame rejected, then a valid one
        fe0 = fe_cnt;
        ld0 = ld_cnt;
        frame(32'h12345, 19);
        check("t2_frame_err", fe_cnt, fe0 + 1);
        check("t2_compare_kept", compare, 20'hABCDE);
        check("t2_pending", pending, 1'b0);
        check("t2_no_load", ld_cnt, ld0);
        exp_q.push_back(20'h00010);
        frame(32'h00010, 20);
        sb_drain("t2_sb");
        check("t2_compare", compare, 20'h00010);

        // Overrun frame rejected, next frame accepted
        fe0 = fe_cnt;
        frame(32'h1FFFFF, 21);
        check("t3_frame_err", fe_cnt, fe0 + 1);
        check("t3_compare_kept", compare, 20'h00010);
        exp_q.push_back(20'h12345);
        frame(32'h12345, 20);
        sb_drain("t3_sb");
        check("t3_no_extra_err", fe_cnt, fe0 + 1);

        // Deferred apply waits for compare_match
        exp_q.push_back(20'h00008);
        frame(32'h00008, 20);
        sb_drain("t4_pre_sb");
        update_mode = 1'b1;
        frame(32'h00004, 20);
        cyc(5);
        check("t4_pending_held", pending, 1'b1);
        check("t4_compare_held", compare, 20'h00008);
        exp_q.push_back(20'h00004);
        compare_match = 1'b1;
        cyc(1);
        compare_match = 1'b0;
        check("t4_compare_new", compare, 20'h00004);
        check("t4_pending_clr", pending, 1'b0);
        check("t4_load_done", load_done, 1'b1);
        cyc(1);
        check("t4_load_done_end", load_done, 1'b0);
        sb_drain("t4_sb");

        // Last committed value wins
        exp_q.push_back(20'h00007);
        frame(32'h00005, 20);
        frame(32'h00007, 20);
        check("t5_pending", pending, 1'b1);
        check("t5_compare_held", compare, 20'h00004);
        ld0 = ld_cnt;
        compare_match = 1'b1;
        cyc(1);
        compare_match = 1'b0;
        cyc(2);
        check("t5_compare", compare, 20'h00007);
        check("t5_pending_clr", pending, 1'b0);
        check("t5_single_load", ld_cnt, ld0 + 1);
        sb_drain("t5_sb");

        // Commit lands on the same cycle as compare_match
        frame(32'h0000A, 20);
        send_bits(32'h0000B, 20);
        exp_q.push_back(20'h0000A);
        ser_latch = 1'b1;
        cyc(2);
        compare_match = 1'b1;
        cyc(1);
        compare_match = 1'b0;
        check("t5b_compare_old_shadow", compare, 20'h0000A);
        check("t5b_pending_kept", pending, 1'b1);
        check("t5b_load_done", load_done, 1'b1);
        cyc(3);
        ser_latch = 1'b0;
        cyc(4);
        check("t5b_pending_still", pending, 1'b1);
        sb_drain("t5b_sb");
        exp_q.push_back(20'h0000B);
        compare_match = 1'b1;
        cyc(1);
        compare_match = 1'b0;
        check("t5b_compare_new", compare, 20'h0000B);
        check("t5b_pending_clr", pending, 1'b0);
        cyc(2);
        sb_drain("t5b2_sb");

        // Reset in the middle of bit 10
        update_mode = 1'b0;
        exp_q.push_back(20'h5A5A5);
        frame(32'h5A5A5, 20);
        sb_drain("t6_pre_sb");
        send_bits(32'h1FF, 9);
        ser_data = 1'b1;
        cyc(2);
        ser_clk = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check("t6_rst_compare", compare, 20'h00000);
        check("t6_rst_pending", pending, 1'b0);
        ser_clk = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        fe0 = fe_cnt;
        exp_q.push_back(20'hC3A96);
        frame(32'hC3A96, 20);
        sb_drain("t6_sb");
        check("t6_no_err", fe_cnt, fe0);
        check("t6_compare", compare, 20'hC3A96);

        // Reset while a value is pending
        update_mode = 1'b1;
        frame(32'h33333, 20);
        check("t6b_pending", pending, 1'b1);
        rst = 1'b1;
        cyc(1);
        check("t6b_rst_compare", compare, 20'h00000);
        check("t6b_rst_pending", pending, 1'b0);
        rst = 1'b0;
        update_mode = 1'b0;
        cyc(2);
        exp_q.push_back(20'h0F0F0);
        frame(32'h0F0F0, 20);
        sb_drain("t6b_sb");
        check("t6b_compare", compare, 20'h0F0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compare_loader.md
Name: compare_loader

Overview:
- Upstream feeder for the 20-bit compare counter: receives a compare value over a slow 3-wire serial link (ser_clk, ser_data, ser_latch) from the chip pins.
- Presents the value to the counter's compare input atomically, with all bits changing in one clk edge.
- The counter restarts on any compare change, so a partially shifted value must never reach it.
- Optionally defers the update until the counter's next compare_match, so the running period is not cut short.

Parameters:
- WIDTH, 20, compare word width in bits.
- RESET_VALUE, 0, value driven on compare after reset (0 = counter free-running).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ser_clk  input  1  serial shift clock, asynchronous to clk; data is sampled on its rising edge
- ser_data  input  1  serial data, MSB first, asynchronous
- ser_latch  input  1  frame commit strobe, asynchronous; its rising edge ends a frame
- update_mode  input  1  0 = apply immediately, 1 = apply on compare_match; quasi-static
- compare_match  input  1  one-cycle tick from the downstream counter
- compare  output  WIDTH  compare value to the counter (registered)
- pending  output  1  an accepted value is waiting to be applied
- load_done  output  1  one-cycle pulse in the cycle after compare updates
- frame_err  output  1  one-cycle pulse when a bad frame is rejected

Behaviour:
- Reset values (async): compare=RESET_VALUE, pending=0, load_done=0, frame_err=0. Shift register, shadow register, bit counter and synchronizer flops are all 0.
- Synchronization:
  - ser_clk, ser_data and ser_latch each pass through a 2-flop synchronizer. A third flop on ser_clk and ser_latch provides rising-edge detection.
  - ser_data is delayed by the same depth, so the sampled bit aligns with the detected edge.
  - Interface timing: ser_clk high and low ≥3 clk periods. ser_data stable from 1 clk before to 3 clk after each ser_clk rise. ser_latch high ≥3 clk.
- Shifting:
  - On a detected ser_clk rise with synced ser_latch low: shift <= {shift[WIDTH-2:0], data}; bit_cnt increments.
  - bit_cnt saturates at WIDTH+1, meaning overrun.
  - ser_clk edges while synced ser_latch is high are ignored.
- Commit, on a detected ser_latch rise:
  - bit_cnt==WIDTH: shadow <= shift and pending <= 1.
  - Otherwise (short frame or overrun): shadow unchanged, frame_err pulses for 1 cycle.
  - bit_cnt clears to 0 in both cases.
- Apply condition: pending==1 AND (update_mode==0 OR compare_match==1). When it holds:
  - compare <= shadow and pending <= 0 at that edge.
  - load_done=1 in the following cycle only.
- Latency:
  - update_mode=0: compare changes 1 cycle after pending rises, i.e. ~4 clk after the pin-level ser_latch rise.
  - update_mode=1: compare changes on the first compare_match cycle at or after the cycle in which pending is 1.
- Priority and simultaneous events:
  - A new commit while pending=1 overwrites shadow; the last committed value wins and pending stays 1.
  - Commit and apply in the same cycle: the old shadow goes to compare and the new value goes to shadow. Pending stays 1, because commit dominates the clear.
  - A value equal to the current compare is still applied and still pulses load_done. The counter does not restart on it, since it sees no change.
- With update_mode=1 and compare==0, the counter free-runs. compare_match then occurs only when (count+1)==0, once per 2^WIDTH cycles. Software uses update_mode=0 when leaving the 0 state.
- Reset mid-frame or mid-pending discards all partial or pending data; compare returns to RESET_VALUE.
- update_mode is sampled every cycle. Changing it 1→0 while pending applies on the next edge.

Test Plan:
- Reset, then shift 20'hABCDE MSB-first, latch with update_mode=0 -> pending pulses for 1 cycle; compare=20'hABCDE; load_done 1 cycle later; frame_err stays 0.
- Shift only 19 bits then latch -> frame_err single pulse; compare and pending unchanged. Follow with a correct 20-bit frame of 20'h00010 -> compare=20'h00010.
- Shift 21 bits then latch -> frame_err pulse; bit_cnt cleared; the next valid frame is accepted normally.
- update_mode=1, compare=20'h00008, commit 20'h00004 -> pending held high until the compare_match cycle; compare changes on that edge; load_done follows 1 cycle later.
- update_mode=1, commit 20'h00005 then 20'h00007 before any match -> only 20'h00007 is applied; a single load_done. Also force commit on the exact compare_match cycle -> old shadow applied, pending remains 1 with the new value.
- Assert rst during bit 10 of a frame and again while pending=1 -> compare=RESET_VALUE, pending=0; a subsequent full frame loads correctly with no stale bits.
